// File: rtl/delay_fifo_pkg.sv
// Shared definitions for delay_fifo: count-width helper, drop counter width, status bit indices.
// Optional overflow tracking is enabled with DELAY_FIFO_OVF_EN.
package delay_fifo_pkg;

    localparam int DROP_CNT_W = 8;

    // Bit positions of the status flags the top keeps in one registered vector
    typedef enum int unsigned {
        STAT_EMPTY = 0,
        STAT_FULL  = 1,
        STAT_AFULL = 2,
        STAT_OVF   = 3
    } status_bit_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/delay_fifo_age.sv
// One per-entry residency counter: clears to zero on load, counts up when enabled,
// and holds at its maximum instead of wrapping.
module delay_fifo_age #(
    parameter int DELAY_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    output logic [DELAY_WIDTH-1:0] age
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (clr) begin
            age <= '0;
        end else if (en && (age != '1)) begin
            age <= age + 1'b1;
        end
    end

endmodule

// File: rtl/delay_fifo.sv
// Synchronous FIFO where every entry must reside at least delay_cfg cycles before it can pop.
// Define DELAY_FIFO_OVF_EN to track refused writes in ovf_sticky / drop_cnt.
module delay_fifo
    import delay_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int DELAY_WIDTH  = 8,
    parameter int AFULL_THRESH = FIFO_DEPTH - 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic [DELAY_WIDTH-1:0]            delay_cfg,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             data_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              full,
    output logic                              empty,
    output logic                              almost_full,
    output logic                              ovf_sticky,
    output logic [DROP_CNT_W-1:0]             drop_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_THRESH);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready depends only on registered state; out_valid only on registered state and delay_cfg.

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_nxt;
    logic [STAT_AFULL:0]    flags_q;
    logic [DELAY_WIDTH-1:0] age_q [FIFO_DEPTH];
    logic [DELAY_WIDTH-1:0] thresh;
    logic                   head_mature;
    logic                   push;
    logic                   pop;

    assign in_ready = !flags_q[STAT_FULL];
    assign push     = in_valid && in_ready;

    // A zero delay still needs one edge of residency, so the threshold never drops below 1
    assign thresh      = (delay_cfg == '0) ? DELAY_WIDTH'(1) : delay_cfg;
    assign head_mature = (age_q[rd_ptr] >= thresh);
    assign out_valid   = !flags_q[STAT_EMPTY] && head_mature;
    assign pop         = out_valid && out_ready;

    assign data_out    = mem[rd_ptr];
    assign count       = count_q;
    assign empty       = flags_q[STAT_EMPTY];
    assign full        = flags_q[STAT_FULL];
    assign almost_full = flags_q[STAT_AFULL];

    always_comb begin
        count_nxt = count_q;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count_q + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            flags_q <= '0;
            flags_q[STAT_EMPTY] <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            count_q             <= count_nxt;
            flags_q[STAT_EMPTY] <= (count_nxt == '0);
            flags_q[STAT_FULL]  <= (count_nxt == DEPTH_C);
            flags_q[STAT_AFULL] <= (count_nxt >= AFULL_C);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Slot i is occupied when its distance from the head is below the current count
    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_age
        logic [PTR_W-1:0] offs;
        logic             occupied;
        logic             wr_here;

        assign offs     = PTR_W'(i) - rd_ptr;
        assign occupied = (CNT_W'(offs) < count_q);
        assign wr_here  = push && (wr_ptr == PTR_W'(i));

        delay_fifo_age #(
            .DELAY_WIDTH (DELAY_WIDTH)
        ) u_age (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (flush || wr_here),
            .en    (occupied),
            .age   (age_q[i])
        );
    end

`ifdef DELAY_FIFO_OVF_EN
    logic                  ovf_q;
    logic [DROP_CNT_W-1:0] drop_q;
    logic                  drop_evt;

    assign drop_evt = in_valid && !in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else if (flush) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else if (drop_evt) begin
            ovf_q <= 1'b1;
            if (drop_q != '1) drop_q <= drop_q + 1'b1;
        end
    end

    assign ovf_sticky = ovf_q;
    assign drop_cnt   = drop_q;
`else
    assign ovf_sticky = 1'b0;
    assign drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_delay_fifo.sv
// Bench for delay_fifo: queue-based reference model predicts flags and maturity from push times;
// a scoreboard queue checks popped data in order.
module tb_delay_fifo;

    localparam int DW      = 4;
    localparam int DEPTH   = 16;
    localparam int DLW     = 8;
    localparam int AF      = DEPTH - 2;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int AGE_MAX = (1 << DLW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic [DLW-1:0] delay_cfg = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [DW-1:0]  data_in = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [DW-1:0]  data_out;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;
    logic           almost_full;
    logic           ovf_sticky;
    logic [7:0]     drop_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_birth[$];
    logic [DW-1:0] exp_q[$];
    bit m_ovf = 0;
    int m_drop = 0;
    bit mv;
    bit can_push;

    delay_fifo dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .delay_cfg   (delay_cfg),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_in     (data_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .ovf_sticky  (ovf_sticky),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Head is mature once its age (edges since push, saturating) reaches max(delay_cfg,1)
    function automatic bit m_valid();
        int age;
        int thr;
        if (m_birth.size() == 0) return 1'b0;
        age = cyc - m_birth[0];
        if (age > AGE_MAX) age = AGE_MAX;
        thr = (delay_cfg == 0) ? 1 : int'(delay_cfg);
        return age >= thr;
    endfunction

    // Reference model, advanced on every rising edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_birth.delete();
            exp_q.delete();
            m_ovf = 0;
            m_drop = 0;
        end else begin
            if (flush) begin
                m_birth.delete();
                exp_q.delete();
                m_ovf = 0;
                m_drop = 0;
            end else begin
                mv = m_valid();
                can_push = m_birth.size() < DEPTH;
                if (mv && out_ready) void'(m_birth.pop_front());
                if (in_valid && can_push) begin
                    m_birth.push_back(cyc + 1);
                    exp_q.push_back(data_in);
                end else if (in_valid) begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
            cyc++;
        end
    end

    // Flag/handshake checker
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", int'(out_valid), int'(m_valid()));
            chk("count", int'(count), m_birth.size());
            chk("full", int'(full), int'(m_birth.size() == DEPTH));
            chk("empty", int'(empty), int'(m_birth.size() == 0));
            chk("almost_full", int'(almost_full), int'(m_birth.size() >= AF));
            chk("in_ready", int'(in_ready), int'(m_birth.size() < DEPTH));
`ifdef DELAY_FIFO_OVF_EN
            chk("ovf_sticky", int'(ovf_sticky), int'(m_ovf));
            chk("drop_cnt", int'(drop_cnt), m_drop);
`else
            chk("ovf_sticky_off", int'(ovf_sticky), 0);
            chk("drop_cnt_off", int'(drop_cnt), 0);
`endif
        end
    end

    // Data monitor: a transfer will happen at the next edge
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual=%0h expected=none", data_out);
            end else begin
                chk("data_out", int'(data_out), int'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        in_valid = 1'b1;
        data_in  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!out_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        // Reset and idle
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) tick();

        // delay 5, single word
        delay_cfg = 8'd5;
        out_ready = 1'b1;
        push_word(4'hA);
        wait_valid(20, n);
        chk("latency_d5", n, 5);
        chk("data_a", int'(data_out), 'hA);
        tick();
        chk("count_after_pop", int'(count), 0);

        // delay 0 still takes one edge
        delay_cfg = 8'd0;
        push_word(4'h3);
        wait_valid(20, n);
        chk("latency_d0", n, 1);
        tick();

        // Fill and backpressure
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            push_word(DW'(i));
            if (i == AF - 1) chk("afull_at_14", int'(almost_full), 1);
        end
        chk("full_at_16", int'(full), 1);
        chk("in_ready_at_16", int'(in_ready), 0);
        chk("count_at_16", int'(count), DEPTH);
        push_word(4'hF);
        chk("count_after_refused", int'(count), DEPTH);
        out_ready = 1'b1;
        repeat (DEPTH + 2) tick();

        // Runtime delay reduction
        delay_cfg = 8'd200;
        push_word(4'h1);
        push_word(4'h2);
        push_word(4'h3);
        repeat (10) tick();
        chk("held_by_200", int'(out_valid), 0);
        delay_cfg = 8'd4;
        repeat (5) tick();
        chk("drained_after_lower", int'(count), 0);

        // Age saturation at maximum delay
        delay_cfg = 8'(AGE_MAX);
        out_ready = 1'b0;
        push_word(4'h9);
        repeat (300) tick();
        chk("saturated_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        repeat (3) tick();

        // Flush overrides a concurrent push
        delay_cfg = 8'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(DW'($urandom_range(0, 15)));
        flush    = 1'b1;
        in_valid = 1'b1;
        data_in  = 4'h5;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", int'(count), 0);
        chk("flush_empty", int'(empty), 1);
        repeat (3) tick();

        // Overflow into a full FIFO
        for (int i = 0; i < DEPTH; i++) push_word(DW'(i));
        for (int i = 0; i < 3; i++) push_word(4'hE);
`ifdef DELAY_FIFO_OVF_EN
        chk("ovf_set", int'(ovf_sticky), 1);
        chk("drop_3", int'(drop_cnt), 3);
`else
        chk("ovf_tied", int'(ovf_sticky), 0);
        chk("drop_tied", int'(drop_cnt), 0);
`endif
        chk("count_after_ovf", int'(count), DEPTH);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Asynchronous reset mid-drain
        for (int i = 0; i < 8; i++) push_word(DW'(i + 3));
        out_ready = 1'b1;
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_afull", int'(almost_full), 0);
        out_ready = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            data_in   = DW'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) delay_cfg = DLW'($urandom_range(0, 7));
            tick();
        end

        // Final drain
        in_valid  = 1'b0;
        flush     = 1'b0;
        delay_cfg = 8'd0;
        out_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
